alu_pipe_fu: RTL and testbench

Parametrised, pipelined integer ALU functional unit for the out-of-order core. It accepts one issued ALU instruction per cycle under a credit-based `ready`, computes the result over a configurable number of pipeline stages, and holds finished results in an internal output queue until the CDB arbiter selects them with `sel`. A squash input discards all in-flight and queued work on branch mispredict. It replaces the single-slot ALU unit, which blocks after each result until that result is selected.

---
 rtl/alu_pipe_fu_pkg.sv | 48 ++++
 rtl/alu_pipe_fu_if.sv | 24 ++
 rtl/fu_out_queue.sv | 58 +++++
 rtl/alu_pipe_fu.sv | 110 +++++++++++
 tb/tb_alu_pipe_fu.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pipe_fu_pkg.sv
// Shared types for the ALU functional unit: issue packet, result record,
// ALU op encoding and the pipeline stage record.
package alu_pipe_fu_pkg;

  localparam int XLEN  = 32;
  localparam int ARF_W = 5;
  localparam int PRF_W = 6;
  localparam int ROB_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic             valid;
    alu_op_e          op;
    logic [XLEN-1:0]  op1_value;
    logic [XLEN-1:0]  op2_value;
    logic [XLEN-1:0]  pc;
    logic [ARF_W-1:0] dest_arf;
    logic [PRF_W-1:0] dest_prf;
    logic [ROB_W-1:0] rob_entry;
  } FUNC_UNIT_PACKET;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  value;
    logic             value_valid;
    logic [XLEN-1:0]  branch_address;
    logic [PRF_W-1:0] dest_prf;
    logic [ROB_W-1:0] rob_entry;
  } FUNC_OUTPUT;

  typedef struct packed {
    logic       valid;
    FUNC_OUTPUT result;
  } ALU_PIPE_STAGE;

endpackage

// File: rtl/alu_pipe_fu_if.sv
// Issue / result / credit bundle between the scheduler, the ALU unit and the CDB arbiter.
interface alu_pipe_fu_if #(
  parameter int QDEPTH = 3
);
  import alu_pipe_fu_pkg::*;

  FUNC_UNIT_PACKET                  input_instr;
  logic                             sel;
  logic                             squash;
  FUNC_OUTPUT                       out;
  logic                             ready;
  logic [$clog2(QDEPTH+1)-1:0]      occupancy;

  modport master (
    output input_instr, sel, squash,
    input  out, ready, occupancy
  );

  modport slave (
    input  input_instr, sel, squash,
    output out, ready, occupancy
  );

endinterface

// File: rtl/fu_out_queue.sv
// In-order circular result FIFO shared by the functional units; head reads as
// all-zero while empty so the CDB never sees stale fields.
module fu_out_queue
  import alu_pipe_fu_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         push,
  input  FUNC_OUTPUT                   push_data,
  input  logic                         pop,
  input  logic                         flush,
  output FUNC_OUTPUT                   head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  FUNC_OUTPUT       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap so non-power-of-two depths cycle through 0..DEPTH-1 only.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && ((count_reg != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  assign head  = (count_reg != '0) ? mem[rd_ptr_reg] : '0;
  assign count = count_reg;

endmodule

// File: rtl/alu_pipe_fu.sv
// Pipelined integer ALU unit: compute on accept, carry through STAGES-1 registers,
// then hold results in an output queue until the CDB selects them.
module alu_pipe_fu
  import alu_pipe_fu_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int QDEPTH = 3
) (
  input  logic         clock,
  input  logic         reset_n,
  alu_pipe_fu_if.slave fu
);
  localparam int OCC_W = $clog2(QDEPTH + 1);

  logic             accept;
  logic             pop;
  logic             push;
  FUNC_OUTPUT       computed;
  FUNC_OUTPUT       push_data;
  FUNC_OUTPUT       head;
  logic [OCC_W-1:0] occ_reg;
  logic [OCC_W-1:0] q_count;

  function automatic FUNC_OUTPUT alu_compute(input FUNC_UNIT_PACKET p);
    FUNC_OUTPUT r;
    logic [4:0] shamt;
    r     = '0;
    shamt = p.op2_value[4:0];
    r.valid          = 1'b1;
    r.branch_address = p.pc + 32'd4;
    r.value_valid    = (p.dest_arf != '0);
    r.dest_prf       = p.dest_prf;
    r.rob_entry      = p.rob_entry;
    case (p.op)
      ALU_ADD:  r.value = p.op1_value + p.op2_value;
      ALU_SUB:  r.value = p.op1_value - p.op2_value;
      ALU_SLT:  r.value = {31'd0, $signed(p.op1_value) < $signed(p.op2_value)};
      ALU_SLTU: r.value = {31'd0, p.op1_value < p.op2_value};
      ALU_AND:  r.value = p.op1_value & p.op2_value;
      ALU_OR:   r.value = p.op1_value | p.op2_value;
      ALU_XOR:  r.value = p.op1_value ^ p.op2_value;
      ALU_SLL:  r.value = p.op1_value << shamt;
      ALU_SRL:  r.value = p.op1_value >> shamt;
      ALU_SRA:  r.value = $unsigned($signed(p.op1_value) >>> shamt);
      default:  r.value = '0;
    endcase
    return r;
  endfunction

  // Credits come from registered occupancy only, so a same-cycle pop never raises ready.
  assign fu.ready = (occ_reg < OCC_W'(QDEPTH));
  assign accept   = fu.input_instr.valid && fu.ready && !fu.squash;
  assign computed = alu_compute(fu.input_instr);
  assign pop      = fu.sel && (q_count != '0);

  generate
    if (STAGES == 1) begin : g_direct
      assign push      = accept;
      assign push_data = computed;
    end else begin : g_pipe
      for (genvar gi = 0; gi < STAGES - 1; gi++) begin : g_stage
        ALU_PIPE_STAGE stage_reg;
        ALU_PIPE_STAGE stage_in;
        if (gi == 0) begin : g_first
          assign stage_in = '{valid: accept, result: computed};
        end else begin : g_next
          assign stage_in = g_stage[gi-1].stage_reg;
        end
        always_ff @(posedge clock) begin
          if (!reset_n || fu.squash) stage_reg <= '0;
          else                       stage_reg <= stage_in;
        end
      end
      assign push      = g_stage[STAGES-2].stage_reg.valid;
      assign push_data = g_stage[STAGES-2].stage_reg.result;
    end
  endgenerate

  fu_out_queue #(.DEPTH(QDEPTH)) u_queue (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (fu.squash),
    .head      (head),
    .count     (q_count)
  );

  assign fu.out       = head;
  assign fu.occupancy = occ_reg;

  always_ff @(posedge clock) begin
    if (!reset_n || fu.squash) begin
      occ_reg <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   occ_reg <= occ_reg + 1'b1;
        2'b01:   occ_reg <= occ_reg - 1'b1;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n && !fu.squash && fu.input_instr.valid)
      assert (fu.ready) else $error("alu_pipe_fu: issue while not ready was dropped");
  end

endmodule

// File: tb/tb_alu_pipe_fu.sv
// Directed bench for alu_pipe_fu with a cycle-accurate scoreboard of expected results.
module tb_alu_pipe_fu;
  import alu_pipe_fu_pkg::*;

  localparam int STAGES = 2;
  localparam int QDEPTH = 3;
  localparam int OW     = $clog2(QDEPTH + 1);

  typedef struct {
    FUNC_OUTPUT res;
    int         due;
  } sb_t;

  logic clock = 1'b0;
  logic reset_n;
  alu_pipe_fu_if #(.QDEPTH(QDEPTH)) bus ();

  alu_pipe_fu #(.STAGES(STAGES), .QDEPTH(QDEPTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .fu      (bus)
  );

  always #5 clock = ~clock;

  sb_t sb[$];
  int  n_assert  = 0;
  int  n_fail    = 0;
  int  cyc       = 0;
  int  exp_occ   = 0;
  bit  exp_valid = 1'b0;
  bit  exp_ready = 1'b1;
  int  accepts   = 0;
  int  pops      = 0;
  int  tag       = 0;

  function automatic FUNC_OUTPUT model(input FUNC_UNIT_PACKET p);
    FUNC_OUTPUT r;
    int sa;
    r  = '0;
    sa = int'(p.op2_value[4:0]);
    r.valid          = 1'b1;
    r.branch_address = p.pc + 32'd4;
    r.value_valid    = |p.dest_arf;
    r.dest_prf       = p.dest_prf;
    r.rob_entry      = p.rob_entry;
    case (p.op)
      ALU_ADD:  r.value = p.op1_value + p.op2_value;
      ALU_SUB:  r.value = p.op1_value + ~p.op2_value + 32'd1;
      ALU_SLT:  r.value = (int'(p.op1_value) < int'(p.op2_value)) ? 32'd1 : 32'd0;
      ALU_SLTU: r.value = (longint'(p.op1_value) < longint'(p.op2_value)) ? 32'd1 : 32'd0;
      ALU_AND:  r.value = p.op1_value & p.op2_value;
      ALU_OR:   r.value = p.op1_value | p.op2_value;
      ALU_XOR:  r.value = p.op1_value ^ p.op2_value;
      ALU_SLL:  r.value = p.op1_value << sa;
      ALU_SRL:  r.value = p.op1_value >> sa;
      ALU_SRA:  r.value = 32'(int'(p.op1_value) >>> sa);
      default:  r.value = 32'd0;
    endcase
    return r;
  endfunction

  task automatic check_eq(input string t, input logic [127:0] obs, input logic [127:0] exp_v);
    n_assert++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", t, obs, exp_v, cyc);
    end
  endtask

  task automatic check_state();
    FUNC_OUTPUT exp_out;
    exp_valid = (sb.size() > 0) && (sb[0].due <= cyc);
    exp_ready = (exp_occ < QDEPTH);
    exp_out   = exp_valid ? sb[0].res : '0;
    check_eq("out", 128'(bus.out), 128'(exp_out));
    check_eq("occupancy", 128'(bus.occupancy), 128'(exp_occ[OW-1:0]));
    check_eq("ready", 128'(bus.ready), 128'(exp_ready));
  endtask

  task automatic tick();
    bit acc;
    bit pp;
    FUNC_OUTPUT r;
    acc = bus.input_instr.valid && exp_ready && !bus.squash && reset_n;
    pp  = bus.sel && exp_valid && !bus.squash && reset_n;
    r   = model(bus.input_instr);
    @(posedge clock);
    cyc++;
    if (!reset_n || bus.squash) begin
      sb.delete();
      exp_occ = 0;
    end else begin
      if (pp) begin
        $display("cycle %0d: pop  rob=%0d value=%08h", cyc, sb[0].res.rob_entry, sb[0].res.value);
        void'(sb.pop_front());
        pops++;
      end
      if (acc) begin
        $display("cycle %0d: issue op=%0d rob=%0d", cyc, bus.input_instr.op, bus.input_instr.rob_entry);
        sb.push_back('{res: r, due: cyc + STAGES - 1});
        accepts++;
      end
      exp_occ = exp_occ + int'(acc) - int'(pp);
    end
    #1;
    check_state();
  endtask

  task automatic drive(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] arf, input logic [31:0] pc);
    tag++;
    bus.input_instr.valid     = 1'b1;
    bus.input_instr.op        = op;
    bus.input_instr.op1_value = a;
    bus.input_instr.op2_value = b;
    bus.input_instr.pc        = pc;
    bus.input_instr.dest_arf  = arf;
    bus.input_instr.dest_prf  = 6'(tag);
    bus.input_instr.rob_entry = 5'(tag);
  endtask

  task automatic idle();
    bus.input_instr = '0;
  endtask

  initial begin
    alu_op_e mix [7];
    int      n_issued;
    int      budget;
    mix = '{ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SLTU, alu_op_e'(4'd12)};

    reset_n    = 1'b0;
    bus.sel    = 1'b0;
    bus.squash = 1'b0;
    idle();
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Single ADD, latency and pop.
    drive(ALU_ADD, 32'd5, 32'd7, 5'd3, 32'h100);
    tick();
    idle();
    tick();
    check_eq("add_value", 128'(bus.out.value), 128'd12);
    check_eq("add_value_valid", 128'(bus.out.value_valid), 128'd1);
    check_eq("add_branch_address", 128'(bus.out.branch_address), 128'h104);
    bus.sel = 1'b1;
    tick();
    bus.sel = 1'b0;
    check_eq("add_popped", 128'(bus.out.valid), 128'd0);

    // Back-to-back with sel held high.
    bus.sel = 1'b1;
    drive(ALU_SUB, 32'd10, 32'd3, 5'd0, 32'h200);
    tick();
    drive(ALU_SRA, 32'h8000_0000, 32'd4, 5'd4, 32'h204);
    tick();
    check_eq("sub_value", 128'(bus.out.value), 128'd7);
    check_eq("sub_value_valid", 128'(bus.out.value_valid), 128'd0);
    drive(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 5'd5, 32'h208);
    tick();
    check_eq("sra_value", 128'(bus.out.value), 128'hF800_0000);
    idle();
    tick();
    check_eq("slt_value", 128'(bus.out.value), 128'd1);
    tick();
    bus.sel = 1'b0;

    // Credit exhaustion with sel low.
    accepts = 0;
    for (int i = 0; i < 6; i++) begin
      if (exp_ready) drive(ALU_ADD, 32'(i), 32'd100, 5'd1, 32'h300);
      else           idle();
      tick();
    end
    idle();
    check_eq("credit_accepts", 128'(accepts), 128'd3);
    check_eq("credit_ready_low", 128'(bus.ready), 128'd0);
    bus.sel = 1'b1;
    #1;
    check_eq("ready_not_same_cycle", 128'(bus.ready), 128'd0);
    tick();
    check_eq("ready_after_sel", 128'(bus.ready), 128'd1);
    tick();
    tick();
    bus.sel = 1'b0;
    tick();

    // Squash with work in flight and queued, plus a same-cycle issue.
    drive(ALU_ADD, 32'd1, 32'd1, 5'd1, 32'h400);
    tick();
    drive(ALU_ADD, 32'd2, 32'd2, 5'd1, 32'h404);
    tick();
    drive(ALU_ADD, 32'd3, 32'd3, 5'd1, 32'h408);
    tick();
    drive(ALU_XOR, 32'd4, 32'd4, 5'd1, 32'h40C);
    bus.squash = 1'b1;
    tick();
    bus.squash = 1'b0;
    idle();
    check_eq("squash_out_valid", 128'(bus.out.valid), 128'd0);
    check_eq("squash_occupancy", 128'(bus.occupancy), 128'd0);
    check_eq("squash_ready", 128'(bus.ready), 128'd1);
    bus.sel = 1'b1;
    tick();
    tick();
    bus.sel = 1'b0;

    // Pointer wrap: 7 issues, sporadic sel, then drain.
    pops     = 0;
    n_issued = 0;
    budget   = 0;
    while ((n_issued < 7 || sb.size() > 0) && budget < 80) begin
      bus.sel = (n_issued >= 7) ? 1'b1 : 1'($urandom_range(0, 2) == 0);
      if (n_issued < 7 && exp_ready) begin
        drive(mix[n_issued], 32'hF0F0_1234 + 32'(n_issued), 32'h0000_0F03 + 32'(n_issued),
              5'(n_issued), 32'h500 + 32'(4 * n_issued));
        n_issued++;
      end else begin
        idle();
      end
      tick();
      budget++;
    end
    idle();
    bus.sel = 1'b0;
    check_eq("wrap_all_popped", 128'(pops), 128'd7);

    // Reset mid-stream.
    drive(ALU_OR, 32'h11, 32'h22, 5'd2, 32'h600);
    tick();
    drive(ALU_AND, 32'h33, 32'h31, 5'd2, 32'h604);
    tick();
    idle();
    reset_n = 1'b0;
    tick();
    check_eq("reset_out_zero", 128'(bus.out), 128'd0);
    check_eq("reset_occupancy", 128'(bus.occupancy), 128'd0);
    check_eq("reset_ready", 128'(bus.ready), 128'd1);
    reset_n = 1'b1;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
